// File: rtl/gen_enable_pkg.sv
// Shared constants for gen_enable: FSM state encodings and the pulse counter width.
package gen_enable_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SINGLE = 2'd2;
  localparam int PULSE_CNT_W = 16;
endpackage

// File: rtl/cnt_mod_p.sv
// Wrapping modulo counter: counts 0..max, returns to 0; tc flags the terminal value.
module cnt_mod_p #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] max,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  assign tc = (count == max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || tc) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/gen_enable.sv
// Periodic / single-shot enable pulse generator.
// Optional feature macro GEN_ENABLE_PULSE_CNT_EN adds a saturating pulse_cnt output.
module gen_enable
  import gen_enable_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] period,
  output logic             en,
  output logic             busy,
  output logic             done
`ifdef GEN_ENABLE_PULSE_CNT_EN
  ,
  output logic [PULSE_CNT_W-1:0] pulse_cnt
`endif
);

  logic [1:0]       state;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] max;
  logic             tc;
  logic             accept;
  logic             fire;

  // A zero period behaves as P=1, so the terminal count is 0 in both cases.
  assign max    = (p_reg == '0) ? '0 : p_reg - WIDTH'(1);
  assign accept = (state == IDLE) && start && !stop;
  // SINGLE stays put for the cycle its en is high, so gate off a second fire there.
  assign fire   = !stop && tc && ((state == RUN) || ((state == SINGLE) && !en));

  cnt_mod_p #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == IDLE),
    .max  (max),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p_reg <= '0;
      en    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      en   <= fire;
      done <= fire && (state == SINGLE);
      case (state)
        IDLE: begin
          if (accept) begin
            p_reg <= period;
            state <= oneshot ? SINGLE : RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SINGLE: begin
          if (stop || en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GEN_ENABLE_PULSE_CNT_EN
  function automatic logic [PULSE_CNT_W-1:0] sat_inc(input logic [PULSE_CNT_W-1:0] v);
    return (v == '1) ? v : v + PULSE_CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt <= '0;
    end else if (accept) begin
      pulse_cnt <= '0;
    end else if (fire) begin
      pulse_cnt <= sat_inc(pulse_cnt);
    end
  end
`endif

endmodule
